s444w_bist_driver: RTL and testbench

Built-in self-test driver for the `s444w` sequential core: it generates the core's three primary-input stimuli and compacts its six primary outputs into a signature. It sits opposite `s444w` in the test harness, driving `G0`/`G1`/`G2` and observing `G107`/`G108`/`G118`/`G119`/`G167`/`G168`. It also reports a pass/fail verdict against a golden signature.

---
 rtl/s444w_bist_driver.sv | 208 ++++++++++++++++++++
 tb/tb_s444w_bist_driver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s444w_bist_driver.sv
// s444w_bist_driver
// BIST driver for the s444w core. It flushes the core through G0, applies
// NPAT LFSR-derived patterns on G1/G2, compacts the six core outputs into a
// 16-bit MISR and compares the final signature against GOLDEN.
// Optional build macro: S444W_BIST_G0_RAND_EN. When it is defined, G0 is
// randomised during RUN (PI[0] = lfsr[0]). When it is undefined, G0 is held
// low for the whole of RUN.
module s444w_bist_driver #(
    parameter logic [7:0]  NPAT      = 8'd255,
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter logic [15:0] GOLDEN    = 16'h0000,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic        CLOCK,
    input  logic        RESETN,
    input  logic        START,
    output logic [2:0]  PI,
    input  logic [5:0]  PO,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [15:0] SIG,
    output logic [7:0]  PATCNT
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [7:0] SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYC - 1);

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // One MISR compaction step with the CCITT polynomial 0x1021.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'd0, d};
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_flcnt;
    logic [3:0]  w_flcnt_nxt;
    logic [7:0]  r_lfsr;
    logic [7:0]  w_lfsr_nxt;
    logic        r_cap;
    logic        w_cap_nxt;
    logic [15:0] r_sig;
    logic [15:0] w_sig_nxt;
    logic [7:0]  r_patcnt;
    logic [7:0]  w_patcnt_nxt;
    logic [2:0]  r_pi;
    logic [2:0]  w_pi_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_pass;
    logic        w_pass_nxt;
    logic        w_enter_flush;

    // State register; reset returns the sequencer to IDLE.
    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; START is only honoured in IDLE and DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_FLUSH: begin
                if (r_flcnt == FLUSH_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_RUN: begin
                if (r_patcnt == NPAT) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values, keyed on the state being entered so
    // that every output can be registered without losing a cycle.
    always_comb begin
        w_enter_flush = (w_state_nxt == ST_FLUSH) && (r_state != ST_FLUSH);
        w_pi_nxt      = 3'b000;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_pass_nxt    = 1'b0;
        w_flcnt_nxt   = r_flcnt;
        w_lfsr_nxt    = r_lfsr;
        w_patcnt_nxt  = r_patcnt;
        // The capture stage trails RUN by one cycle to absorb the core's
        // one-flop response latency; the last sample lands in DRAIN.
        w_cap_nxt     = (r_state == ST_RUN);
        if (r_cap) begin
            w_sig_nxt = misr_step(r_sig, PO);
        end else begin
            w_sig_nxt = r_sig;
        end
        case (w_state_nxt)
            ST_FLUSH: begin
                w_pi_nxt   = 3'b001;
                w_busy_nxt = 1'b1;
                if (w_enter_flush) begin
                    w_flcnt_nxt  = 4'd0;
                    w_lfsr_nxt   = SEED_EFF;
                    w_patcnt_nxt = 8'd0;
                    w_sig_nxt    = 16'h0000;
                end else begin
                    w_flcnt_nxt  = r_flcnt + 4'd1;
                end
            end
            ST_RUN: begin
`ifdef S444W_BIST_G0_RAND_EN
                w_pi_nxt = {r_lfsr[2], r_lfsr[1], r_lfsr[0]};
`else
                w_pi_nxt = {r_lfsr[2], r_lfsr[1], 1'b0};
`endif
                w_busy_nxt = 1'b1;
                w_lfsr_nxt = lfsr_step(r_lfsr);
                if (r_patcnt == NPAT) begin
                    w_patcnt_nxt = r_patcnt;
                end else begin
                    w_patcnt_nxt = r_patcnt + 8'd1;
                end
            end
            ST_DRAIN: begin
                w_busy_nxt = 1'b1;
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
                if (r_state != ST_DONE) begin
                    w_pass_nxt = (w_sig_nxt == GOLDEN);
                end else begin
                    w_pass_nxt = r_pass;
                end
            end
            default: begin
                w_pi_nxt = 3'b000;
            end
        endcase
    end

    // Datapath and output registers; reset discards any partial signature.
    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            r_flcnt  <= 4'd0;
            r_lfsr   <= SEED_EFF;
            r_cap    <= 1'b0;
            r_sig    <= 16'h0000;
            r_patcnt <= 8'd0;
            r_pi     <= 3'b000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_flcnt  <= w_flcnt_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_cap    <= w_cap_nxt;
            r_sig    <= w_sig_nxt;
            r_patcnt <= w_patcnt_nxt;
            r_pi     <= w_pi_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_pass   <= w_pass_nxt;
        end
    end

    assign PI     = r_pi;
    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign PASS   = r_pass;
    assign SIG    = r_sig;
    assign PATCNT = r_patcnt;

endmodule

// File: tb/tb_s444w_bist_driver.sv
// Testbench for s444w_bist_driver. Four instances with different
// configurations share the clock, reset and PO bus; each has its own START.
// Every expectation comes from a timeline model relative to the START edge.
module tb_s444w_bist_driver;

    logic        clk;
    logic        rstn;
    logic [5:0]  po;
    logic        start_v  [4];
    logic [2:0]  pi_o     [4];
    logic        busy_o   [4];
    logic        done_o   [4];
    logic        pass_o   [4];
    logic [15:0] sig_o    [4];
    logic [7:0]  patcnt_o [4];

    logic [5:0]  po_seq [280];
    int          n_checks;
    int          n_fail;

    s444w_bist_driver #(.NPAT(8'd4), .SEED(8'hA5), .GOLDEN(16'h000F), .FLUSH_CYC(2)) u_dut0 (
        .CLOCK(clk), .RESETN(rstn), .START(start_v[0]), .PI(pi_o[0]), .PO(po),
        .BUSY(busy_o[0]), .DONE(done_o[0]), .PASS(pass_o[0]), .SIG(sig_o[0]), .PATCNT(patcnt_o[0]));
    s444w_bist_driver #(.NPAT(8'd4), .SEED(8'h01), .GOLDEN(16'h0000), .FLUSH_CYC(1)) u_dut1 (
        .CLOCK(clk), .RESETN(rstn), .START(start_v[1]), .PI(pi_o[1]), .PO(po),
        .BUSY(busy_o[1]), .DONE(done_o[1]), .PASS(pass_o[1]), .SIG(sig_o[1]), .PATCNT(patcnt_o[1]));
    s444w_bist_driver #(.NPAT(8'd255), .SEED(8'h00), .GOLDEN(16'h0000), .FLUSH_CYC(2)) u_dut2 (
        .CLOCK(clk), .RESETN(rstn), .START(start_v[2]), .PI(pi_o[2]), .PO(po),
        .BUSY(busy_o[2]), .DONE(done_o[2]), .PASS(pass_o[2]), .SIG(sig_o[2]), .PATCNT(patcnt_o[2]));
    s444w_bist_driver #(.NPAT(8'd1), .SEED(8'h5A), .GOLDEN(16'h0000), .FLUSH_CYC(15)) u_dut3 (
        .CLOCK(clk), .RESETN(rstn), .START(start_v[3]), .PI(pi_o[3]), .PO(po),
        .BUSY(busy_o[3]), .DONE(done_o[3]), .PASS(pass_o[3]), .SIG(sig_o[3]), .PATCNT(patcnt_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_np(input int idx);
        case (idx)
            0: return 4;
            1: return 4;
            2: return 255;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_fc(input int idx);
        case (idx)
            0: return 2;
            1: return 1;
            2: return 2;
            default: return 15;
        endcase
    endfunction

    function automatic logic [7:0] cfg_seed(input int idx);
        case (idx)
            0: return 8'hA5;
            1: return 8'h01;
            2: return 8'h00;
            default: return 8'h5A;
        endcase
    endfunction

    function automatic logic [15:0] cfg_gold(input int idx);
        case (idx)
            0: return 16'h000F;
            default: return 16'h0000;
        endcase
    endfunction

    // Next LFSR value: double modulo 256, add parity of taps 7,5,4,3.
    function automatic logic [7:0] m_lfsr_next(input logic [7:0] l);
        int v;
        v = ((int'(l) * 2) % 256) + ($countones(l & 8'hB8) % 2);
        return 8'(v);
    endfunction

    // Signature update: double modulo 2^16, fold in 0x1021 on carry-out, xor PO.
    function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [5:0] d);
        int v;
        v = (int'(s) * 2) % 65536;
        if (int'(s) >= 32768) v = v ^ 32'h1021;
        v = v ^ int'(d);
        return 16'(v);
    endfunction

    function automatic logic [2:0] m_pat(input logic [7:0] l);
`ifdef S444W_BIST_G0_RAND_EN
        return {l[2], l[1], l[0]};
`else
        return {l[2], l[1], 1'b0};
`endif
    endfunction

    // Full run on instance idx, checking every output every cycle.
    // START is re-pulsed before edge k+mid_t (0 = never).
    task automatic run_check(input int idx, input int mid_t);
        int np, fc;
        logic [7:0]  l;
        logic [15:0] es;
        logic [2:0]  epi;
        logic        eb, ed, ep;
        logic [7:0]  epc;
        np = cfg_np(idx);
        fc = cfg_fc(idx);
        l  = (cfg_seed(idx) == 8'h00) ? 8'h01 : cfg_seed(idx);
        es = 16'h0000;
        @(negedge clk);
        start_v[idx] = 1'b1;
        po = po_seq[0];
        for (int t = 0; t <= fc + np + 2; t++) begin
            @(posedge clk);
            if (t >= fc + 2 && t <= fc + np + 1) es = m_misr(es, po_seq[t]);
            if (t < fc) begin
                epi = 3'b001; eb = 1'b1; ed = 1'b0; epc = 8'd0;
            end else if (t < fc + np) begin
                epi = m_pat(l); l = m_lfsr_next(l);
                eb = 1'b1; ed = 1'b0; epc = 8'(t - fc + 1);
            end else if (t == fc + np) begin
                epi = 3'b000; eb = 1'b1; ed = 1'b0; epc = 8'(np);
            end else begin
                epi = 3'b000; eb = 1'b0; ed = 1'b1; epc = 8'(np);
            end
            ep = ed ? (es == cfg_gold(idx)) : 1'b0;
            @(negedge clk);
            n_checks++;
            if ({pi_o[idx], busy_o[idx], done_o[idx]} !== {epi, eb, ed}) begin
                n_fail++;
                $display("FAIL run%0d t=%0d pi/busy/done got %b/%b/%b expected %b/%b/%b",
                         idx, t, pi_o[idx], busy_o[idx], done_o[idx], epi, eb, ed);
            end
            n_checks++;
            if (patcnt_o[idx] !== epc) begin
                n_fail++;
                $display("FAIL run%0d t=%0d patcnt got %0d expected %0d", idx, t, patcnt_o[idx], epc);
            end
            n_checks++;
            if (sig_o[idx] !== es) begin
                n_fail++;
                $display("FAIL run%0d t=%0d sig got %h expected %h", idx, t, sig_o[idx], es);
            end
            n_checks++;
            if (pass_o[idx] !== ep) begin
                n_fail++;
                $display("FAIL run%0d t=%0d pass got %b expected %b", idx, t, pass_o[idx], ep);
            end
            start_v[idx] = (t + 1 == mid_t);
            po = po_seq[t + 1];
        end
        start_v[idx] = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 280; i++) po_seq[i] = 6'($urandom_range(0, 63));
    endtask

    task automatic fill_const(input logic [5:0] v);
        for (int i = 0; i < 280; i++) po_seq[i] = v;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({pi_o[i], busy_o[i], done_o[i], pass_o[i], sig_o[i], patcnt_o[i]} !== 30'd0) begin
                n_fail++;
                $display("FAIL reset%0d pi=%b busy=%b done=%b pass=%b sig=%h patcnt=%0d expected all zero",
                         i, pi_o[i], busy_o[i], done_o[i], pass_o[i], sig_o[i], patcnt_o[i]);
            end
        end
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pass_fail();
        fill_const(6'h01);
        run_check(0, 0);
        n_checks++;
        if (sig_o[0] !== 16'h000F || pass_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL golden_match sig=%h pass=%b expected 000f/1", sig_o[0], pass_o[0]);
        end
        run_check(1, 0);
        n_checks++;
        if (sig_o[1] !== 16'h000F || pass_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL golden_miss sig=%h pass=%b expected 000f/0", sig_o[1], pass_o[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                fill_random();
                run_check(i, 0);
            end
        end
    endtask

    task automatic test_lfsr_full();
        fill_random();
        run_check(2, 0);
        fill_random();
        run_check(2, 0);
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_check(0, 4);
        run_check(1, 1);
        run_check(3, 17);
    endtask

    task automatic test_reset_midrun();
        fill_random();
        @(negedge clk);
        start_v[0] = 1'b1;
        po = po_seq[0];
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            @(negedge clk);
            start_v[0] = 1'b0;
            po = po_seq[t + 1];
        end
        rstn = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({pi_o[0], busy_o[0], done_o[0], pass_o[0], sig_o[0], patcnt_o[0]} !== 30'd0) begin
            n_fail++;
            $display("FAIL midrun_reset pi=%b busy=%b done=%b sig=%h patcnt=%0d expected all zero",
                     pi_o[0], busy_o[0], done_o[0], sig_o[0], patcnt_o[0]);
        end
        rstn = 1'b1;
        start_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins busy got %b expected 0", busy_o[0]);
        end
        run_check(0, 0);
    endtask

    task automatic test_g0_mode();
        int fc, np;
        fc = cfg_fc(1);
        np = cfg_np(1);
        fill_random();
        @(negedge clk);
        start_v[1] = 1'b1;
        for (int t = 0; t <= fc + np + 1; t++) begin
            @(posedge clk);
            @(negedge clk);
            start_v[1] = 1'b0;
            if (t >= fc && t < fc + np) begin
                n_checks++;
`ifdef S444W_BIST_G0_RAND_EN
                if (t == fc && pi_o[1][0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL g0_rand t=%0d pi0 got %b expected 1", t, pi_o[1][0]);
                end
`else
                if (pi_o[1][0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL g0_low t=%0d pi0 got %b expected 0", t, pi_o[1][0]);
                end
`endif
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        po       = 6'd0;
        rstn     = 1'b0;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        test_reset();
        test_pass_fail();
        test_back_to_back();
        test_lfsr_full();
        test_start_ignored();
        test_reset_midrun();
        test_g0_mode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
